// File: rtl/seg7_display_arbiter_if.sv
// Bundle between the digit sources and the shared 7-segment display arbiter.
//
// Handshake: req[i] is a level "valid" owned by source i, and grant[i] is the
// matching "ready/ack". A source keeps req[i] high for as long as it wants the
// display. While grant[i] is high, digit_out carries the code that was latched
// at grant time. Dropping req[i] while granted releases the display on the
// next edge. digit_vld equals |grant, and done marks the last cycle of a
// dwell that ran to completion.
interface seg7_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] digit_in;
    logic [NUM_REQ-1:0]   grant;
    logic [3:0]           digit_out;
    logic                 digit_vld;
    logic                 done;

    // Sources side: drives requests and codes, observes the grant.
    modport master (
        output req,
        output digit_in,
        input  grant,
        input  digit_out,
        input  digit_vld,
        input  done
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  digit_in,
        output grant,
        output digit_out,
        output digit_vld,
        output done
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter that shares one 7-segment digit between NUM_REQ sources.
// Each winner holds the display for DWELL_COUNT cycles unless it releases early.
// Its 4-bit code is frozen on digit_out for the whole grant.
module seg7_display_arbiter #(
    parameter int                NUM_REQ     = 4,
    parameter int                CNT_W       = 24,
    parameter logic [CNT_W-1:0]  DWELL_COUNT = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_display_arbiter_if.slave bus,
    output logic                  dbg_state
);

    localparam int               PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST  = DWELL_COUNT - 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [3:0]         digit_q, digit_n;
    logic               vld_q, vld_n;
    logic               done_q, done_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [PTR_W-1:0]   rr_q, rr_n;

    logic               held;
    logic               last;
    logic               arb;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [NUM_REQ-1:0] win_onehot;
    logic [3:0]         win_code;

    // Round-robin search starting just after the previous winner; the previous
    // winner is visited last, so it only wins again when it is the sole requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            logic [PTR_W:0] sum;
            logic [PTR_W:0] wrapped;
            sum     = {1'b0, rr_q} + (PTR_W+1)'(i);
            wrapped = (sum >= (PTR_W+1)'(NUM_REQ)) ? sum - (PTR_W+1)'(NUM_REQ) : sum;
            if (!found && bus.req[wrapped[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = wrapped[PTR_W-1:0];
            end
        end
    end

    // Decode the winner into a one-hot grant and select its code.
    always_comb begin
        win_onehot = '0;
        win_code   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win == PTR_W'(j)) begin
                win_onehot[j] = 1'b1;
                win_code      = bus.digit_in[4*j +: 4];
            end
        end
    end

    // The current holder still wants the display; grant is never multi-hot.
    assign held = |(bus.req & grant_q);
    assign last = (cnt_q == LAST);
    // Re-arbitrate when idle, on the final dwell cycle, or on an early release.
    assign arb  = (state_q == IDLE) || !held || last;

    // Next-state and next-output logic for the IDLE/SHOW controller.
    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        digit_n = digit_q;
        vld_n   = vld_q;
        cnt_n   = cnt_q;
        rr_n    = rr_q;
        if (arb) begin
            cnt_n = '0;
            if (found) begin
                state_n = SHOW;
                grant_n = win_onehot;
                digit_n = win_code;
                vld_n   = 1'b1;
                rr_n    = win;
            end else begin
                state_n = IDLE;
                grant_n = '0;
                vld_n   = 1'b0;
            end
        end else begin
            cnt_n = cnt_q + 1'b1;
        end
        // Flag the upcoming last dwell cycle one edge early so done is a flop.
        done_n = (state_n == SHOW) && (cnt_n == LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            digit_q <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            digit_q <= digit_n;
            vld_q   <= vld_n;
            done_q  <= done_n;
            cnt_q   <= cnt_n;
            rr_q    <= rr_n;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.digit_out = digit_q;
    assign bus.digit_vld = vld_q;
    // A holder that drops its request on the last cycle is a release, not a
    // completion, so the registered flag is qualified by the live request.
    assign bus.done      = done_q & held;
    assign dbg_state     = (state_q == SHOW);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with NUM_REQ=4 and DWELL_COUNT=4.
module tb_seg7_display_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 24;

    logic clk;
    logic reset;
    logic dbg_state;
    int   checks;
    int   failures;

    seg7_display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    seg7_display_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CNT_W       (CNT_W),
        .DWELL_COUNT (24'd4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1);
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                              input logic v, input logic dn, input bit chk_d);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        if (chk_d) check({tag, ".digit"}, 32'(bus.digit_out), 32'(d));
        check({tag, ".vld"}, 32'(bus.digit_vld), 32'(v));
        check({tag, ".done"}, 32'(bus.done), 32'(dn));
        check({tag, ".state"}, 32'(dbg_state), 32'(v));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.req      = 4'hF;
        bus.digit_in = 16'h0000;

        // Reset held with all requests up.
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("t1_rst", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        reset   = 1'b0;
        bus.req = 4'h0;
        step();
        expect_out("t1_idle", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);

        // Single requester: grant next cycle, done on 4th cycle, gapless re-grant.
        bus.req      = 4'b0100;
        bus.digit_in = 16'h0700;
        step();
        expect_out("t2_c0", 4'b0100, 4'd7, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t2_c1", 4'b0100, 4'd7, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t2_c2", 4'b0100, 4'd7, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t2_c3", 4'b0100, 4'd7, 1'b1, 1'b1, 1'b1);
        step();
        expect_out("t2_regrant", 4'b0100, 4'd7, 1'b1, 1'b0, 1'b1);
        bus.req = 4'h0;
        step();
        expect_out("t2_idle", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Re-reset so the pointer starts at NUM_REQ-1.
        reset = 1'b1;
        step();
        expect_out("t3_rst", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        // Round robin over all four sources, wrapping back to source 0.
        bus.req      = 4'hF;
        bus.digit_in = 16'h4321;
        for (int gi = 0; gi < 5; gi++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                expect_out($sformatf("t3_g%0d_c%0d", gi, c), 4'(1 << (gi % 4)),
                           4'((gi % 4) + 1), 1'b1, (c == 3), 1'b1);
            end
        end
        bus.req = 4'h0;
        step();
        expect_out("t3_idle", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Code frozen during the dwell; the new code appears at the next grant.
        bus.req      = 4'b0010;
        bus.digit_in = 16'h0090;
        step();
        expect_out("t4_c0", 4'b0010, 4'd9, 1'b1, 1'b0, 1'b1);
        bus.digit_in = 16'h0030;
        step();
        expect_out("t4_c1", 4'b0010, 4'd9, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t4_c2", 4'b0010, 4'd9, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t4_c3", 4'b0010, 4'd9, 1'b1, 1'b1, 1'b1);
        step();
        expect_out("t4_new", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b1);

        // Early release of source 1 in dwell cycle 2 hands over to source 3.
        bus.digit_in = 16'h5030;
        bus.req      = 4'b1010;
        step();
        expect_out("t5_c1", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t5_c2", 4'b0010, 4'd3, 1'b1, 1'b0, 1'b1);
        bus.req = 4'b1000;
        step();
        expect_out("t5_handover", 4'b1000, 4'd5, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t5_s3_c1", 4'b1000, 4'd5, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t5_s3_c2", 4'b1000, 4'd5, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t5_s3_c3", 4'b1000, 4'd5, 1'b1, 1'b1, 1'b1);
        // Release on the last cycle counts as a release: done must drop.
        bus.req      = 4'b0100;
        bus.digit_in = 16'h5630;
        #1;
        check("t5_simul.done", 32'(bus.done), 32'd0);
        check("t5_simul.grant", 32'(bus.grant), 32'h8);
        step();
        expect_out("t5_next", 4'b0100, 4'd6, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a dwell, then restart from source 0.
        step();
        expect_out("t6_c1", 4'b0100, 4'd6, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t6_c2", 4'b0100, 4'd6, 1'b1, 1'b0, 1'b1);
        reset        = 1'b1;
        bus.req      = 4'hF;
        bus.digit_in = 16'hABCD;
        step();
        expect_out("t6_rst", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        expect_out("t6_first", 4'b0001, 4'd13, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("t6_c1", 4'b0001, 4'd13, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
